mult_seq_ctrl: RTL and testbench

Multi-cycle shift-add multiplier sequencer for the miniComputer ALU.
- Accepts two unsigned N-bit operands and drives the shared N-bit carry-lookahead adder for N iterations.
- Returns a 2N-bit product over a valid/ready result interface.
- The adder stays outside this block: the controller only sequences it through dedicated operand and sum ports.

---
 rtl/mult_seq_ctrl.sv | 87 ++++++++
 tb/tb_mult_seq_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// Shift-add multiplier sequencer: drives an external N-bit adder for N passes
// and returns the 2N-bit unsigned product over a valid/ready interface.
module mult_seq_ctrl #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           in_ready,
  input  logic [N-1:0]   op_a,
  input  logic [N-1:0]   op_b,
  output logic [N-1:0]   add_a,
  output logic [N-1:0]   add_b,
  output logic           add_cin,
  input  logic [N-1:0]   add_sum,
  input  logic           add_cout,
  output logic [2*N-1:0] product,
  output logic           res_valid,
  input  logic           res_ready,
  output logic           busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  acc;
  logic [N-1:0]  mq;
  logic [N-1:0]  mcand;
  logic [CW-1:0] cnt;
  logic          armed;
  logic          accept;

  // armed is low until the first edge after reset release, so a start that
  // coincides with reset deassertion is never taken.
  assign accept = (state == S_IDLE) && armed && start;

  // NOTE: every register here is state, so all use non-blocking assignments
  // and clear on the asynchronous reset; no flop is left uninitialised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
      mq    <= '0;
      mcand <= '0;
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            mcand <= op_a;
            mq    <= op_b;
            acc   <= '0;
            cnt   <= '0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          // Shift the sum right into acc:mq; the adder carry becomes acc's MSB.
          acc <= {add_cout, add_sum[N-1:1]};
          mq  <= {add_sum[0], mq[N-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) state <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The shared adder sees zeros whenever this block is not computing.
  assign add_a   = (state == S_CALC) ? acc : '0;
  assign add_b   = ((state == S_CALC) && mq[0]) ? mcand : '0;
  assign add_cin = 1'b0;

  assign in_ready  = (state == S_IDLE) && armed;
  assign busy      = (state == S_CALC) || (state == S_DONE);
  assign res_valid = (state == S_DONE);
  assign product   = res_valid ? {acc, mq} : '0;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed and random jobs compared
// against an arithmetic model of shift-add multiplication.
module tb_mult_seq_ctrl;
  localparam int N  = 8;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           in_ready;
  logic [N-1:0]   op_a, op_b;
  logic [N-1:0]   add_a, add_b;
  logic           add_cin;
  logic [N-1:0]   add_sum;
  logic           add_cout;
  logic [2*N-1:0] product;
  logic           res_valid;
  logic           res_ready;
  logic           busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Behavioural carry-lookahead adder stand-in.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

  mult_seq_ctrl #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .product(product),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one job from IDLE (called at a negedge) and returns whether the adder
  // carried during any pass. poke >= 0 raises start during that CALC pass.
  task automatic run_job(input int a, input int b, input int hold, input int poke,
                         output bit carry_seen);
    int exp_acc;
    int exp_addb;
    int exp_prod;
    exp_prod = a * b;
    carry_seen = 1'b0;
    check("idle_in_ready", in_ready, 1);
    op_a = a[N-1:0];
    op_b = b[N-1:0];
    start = 1'b1;
    res_ready = (hold == 0);
    @(negedge clk);
    start = 1'b0;
    op_a = N'($urandom);
    op_b = N'($urandom);
    for (int i = 0; i < N; i++) begin
      exp_acc  = (a * (b & ((1 << i) - 1))) >> i;
      exp_addb = ((b >> i) & 1) ? a : 0;
      check("calc_busy", busy, 1);
      check("calc_res_valid", res_valid, 0);
      check("calc_add_a", add_a, exp_acc);
      check("calc_add_b", add_b, exp_addb);
      if (add_cout) carry_seen = 1'b1;
      if (i == poke) begin
        start = 1'b1;
        op_a = 8'd200;
        op_b = 8'd200;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_res_valid", res_valid, 1);
    check("done_product", product, exp_prod);
    check("done_add_b", add_b, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_res_valid", res_valid, 1);
      check("hold_product", product, exp_prod);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("post_res_valid", res_valid, 0);
    check("post_busy", busy, 0);
    check("post_in_ready", in_ready, 1);
    check("post_add_a", add_a, 0);
    check("post_add_b", add_b, 0);
  endtask

  initial begin
    bit cy;
    int ra, rb;
    rst_n = 1'b0;
    start = 1'b0;
    res_ready = 1'b0;
    op_a = '0;
    op_b = '0;
    repeat (2) @(negedge clk);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_add_cin", add_cin, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);

    // Basic, max, zero, identity
    run_job(13, 11, 0, -1, cy);
    run_job(255, 255, 0, -1, cy);
    check("max_carry_seen", cy, 1);
    run_job(8'h5A, 0, 0, -1, cy);
    run_job(1, 8'hC3, 0, -1, cy);

    // Backpressure
    run_job(7, 9, 5, -1, cy);

    // Start while busy must be ignored
    run_job(3, 5, 0, 2, cy);
    @(negedge clk);
    check("ignored_start_busy", busy, 0);
    check("ignored_start_add_a", add_a, 0);
    check("ignored_start_add_b", add_b, 0);

    // Reset during the fourth CALC cycle
    op_a = 8'd5;
    op_b = 8'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_res_valid", res_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_product", product, 0);
    check("abort_add_a", add_a, 0);
    // Release reset with start already high: that edge must not accept.
    start = 1'b1;
    op_a = 8'd9;
    op_b = 8'd9;
    #2 rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rel_start_busy", busy, 0);
    check("rel_start_in_ready", in_ready, 1);
    repeat (N + 2) @(negedge clk);
    check("no_result_after_abort", res_valid, 0);
    run_job(6, 6, 0, -1, cy);

    // Random jobs
    for (int k = 0; k < 8; k++) begin
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      run_job(ra, rb, int'($urandom_range(0, 3)), -1, cy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
